kerygma_xif_timer: RTL and testbench

//  Memory-mapped timer/compare peripheral on the tile's external (xif) split bus, next to the GPIO CSRs.

---
 rtl/kerygma_timer_pkg.sv | 43 ++++
 rtl/kerygma_xif_timer_if.sv | 21 ++
 rtl/kerygma_timer_prescaler.sv | 32 +++
 rtl/kerygma_xif_timer.sv | 172 +++++++++++++++++
 tb/tb_kerygma_xif_timer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/kerygma_timer_pkg.sv
// Shared definitions for the xif timer/compare peripheral: register offsets,
// CTRL bit positions and layout, and the byte-lane write merge helper.
package kerygma_timer_pkg;

    // Byte offsets from BASE_ADDR
    localparam logic [31:0] OFS_CTRL    = 32'h00;
    localparam logic [31:0] OFS_PRESC   = 32'h04;
    localparam logic [31:0] OFS_COUNT   = 32'h08;
    localparam logic [31:0] OFS_COMPARE = 32'h0C;
    localparam logic [31:0] OFS_STATUS  = 32'h10;

    // Window spans OFS_CTRL..OFS_STATUS+3
    localparam logic [31:0] WIN_SIZE    = 32'h14;

    // CTRL bit indices
    localparam int CTRL_EN         = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_AUTORELOAD = 2;
    localparam int CTRL_ONESHOT    = 3;

    // CTRL layout, MSB first so that en lands on bit 0
    typedef struct packed {
        logic oneshot;
        logic autoreload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Replace only the byte lanes selected by be; be=0 leaves the value untouched
    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/kerygma_xif_timer_if.sv
// Split-bus request/response bundle between the CPU xif port and the timer.
interface kerygma_xif_timer_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/kerygma_timer_prescaler.sv
// Clock divider producing a one-cycle tick every presc+1 clocks while enabled.
// The count restarts whenever the timer is disabled, on each tick, and when
// software reconfigures the timer (clr), so a fresh setup always gets a full period.
module kerygma_timer_prescaler #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] presc,
    input  logic                 clr,
    output logic                 tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] psc_cnt;

    assign tick = en & (psc_cnt == presc);

    // Prescale counter: run 0..presc while enabled, restart on tick/disable/clear
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            psc_cnt <= '0;
        end else if (!en || clr || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/kerygma_xif_timer.sv
// Memory-mapped timer/compare peripheral on the xif split bus.
// Holds the address decode, byte-lane writes, COUNT/COMPARE/pend logic, the
// registered read path and the level interrupt.
module kerygma_xif_timer
    import kerygma_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h80000010,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    kerygma_xif_timer_if.slave  bus,
    output logic                irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Decode
    logic [31:0] ofs;
    logic        hit;
    logic        acc_wr;
    logic        acc_rd;
    logic        wr_ctrl;
    logic        wr_presc;
    logic        wr_count;
    logic        wr_compare;
    logic        clr_pend;
    logic        psc_clr;
    logic        unused_addr;

    // Register state and next-state
    ctrl_t                ctrl_q;
    ctrl_t                ctrl_n;
    logic [CNT_WIDTH-1:0] presc_q;
    logic [CNT_WIDTH-1:0] presc_n;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_n;
    logic [CNT_WIDTH-1:0] compare_q;
    logic [CNT_WIDTH-1:0] compare_n;
    logic                 pend_q;
    logic                 pend_n;

    logic                 tick;
    logic                 match;

    // Read path
    logic [31:0] rd_mux;
    logic        resp_q;
    logic [31:0] rdata_q;

    // Word-aligned offset; BASE_ADDR is word aligned so bits [1:0] of ofs stay 0
    assign ofs         = {bus.addr[31:2], 2'b00} - BASE_ADDR;
    assign hit         = (ofs < WIN_SIZE);
    assign unused_addr = ^bus.addr[1:0];

    assign bus.ack = bus.req & hit;
    assign acc_wr  = bus.ack & bus.we;
    assign acc_rd  = bus.ack & ~bus.we;

    assign wr_ctrl    = acc_wr & (ofs == OFS_CTRL);
    assign wr_presc   = acc_wr & (ofs == OFS_PRESC);
    assign wr_count   = acc_wr & (ofs == OFS_COUNT);
    assign wr_compare = acc_wr & (ofs == OFS_COMPARE);
    assign clr_pend   = acc_wr & (ofs == OFS_STATUS) & bus.be[0] & bus.wdata[0];

    // Reconfiguring timing restarts the prescale period; be=0 writes touch nothing
    assign psc_clr = (wr_ctrl | wr_presc) & (|bus.be);

    kerygma_timer_prescaler #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prescaler (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .en       (ctrl_q.en),
        .presc    (presc_q),
        .clr      (psc_clr),
        .tick     (tick)
    );

    // Compare uses the pre-increment COUNT
    assign match = tick & (count_q == compare_q);

    // Next-state: tick effects first, then software writes override where they collide
    always_comb begin
        ctrl_n    = ctrl_q;
        presc_n   = presc_q;
        count_n   = count_q;
        compare_n = compare_q;
        pend_n    = pend_q;

        if (tick) begin
            if (match && ctrl_q.autoreload) begin
                count_n = '0;
            end else if (match && ctrl_q.oneshot) begin
                ctrl_n.en = 1'b0;
                count_n   = compare_q + CNT_ONE;
            end else begin
                count_n = count_q + CNT_ONE;
            end
        end

        // W1C loses against a simultaneous match
        if (clr_pend) begin
            pend_n = 1'b0;
        end
        if (match) begin
            pend_n = 1'b1;
        end

        // Only lane 0 carries CTRL bits; the written en beats a oneshot auto-disable
        if (wr_ctrl && bus.be[0]) begin
            ctrl_n = ctrl_t'(bus.wdata[3:0]);
        end
        if (wr_presc) begin
            presc_n = CNT_WIDTH'(merge_be(32'(presc_q), bus.wdata, bus.be));
        end
        // A COUNT write discards any tick landing in the same cycle
        if (wr_count) begin
            count_n = CNT_WIDTH'(merge_be(32'(count_q), bus.wdata, bus.be));
        end
        if (wr_compare) begin
            compare_n = CNT_WIDTH'(merge_be(32'(compare_q), bus.wdata, bus.be));
        end
    end

    // Register bank
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '1;
            pend_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_n;
            presc_q   <= presc_n;
            count_q   <= count_n;
            compare_q <= compare_n;
            pend_q    <= pend_n;
        end
    end

    // Read mux; unmapped or idle offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_CTRL:    rd_mux = {28'h0, ctrl_q};
            OFS_PRESC:   rd_mux = 32'(presc_q);
            OFS_COUNT:   rd_mux = 32'(count_q);
            OFS_COMPARE: rd_mux = 32'(compare_q);
            OFS_STATUS:  rd_mux = {31'h0, pend_q};
            default:     rd_mux = '0;
        endcase
    end

    // Read response one cycle after accept; data forced to zero when no response
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= acc_rd;
            rdata_q <= acc_rd ? rd_mux : 32'h0;
        end
    end

    assign bus.resp  = resp_q;
    assign bus.rdata = rdata_q;

    assign irq_o = pend_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_kerygma_xif_timer.sv
// Self-checking bench for kerygma_xif_timer: reads are scoreboarded (expected
// value queued on issue, popped when the response appears); interrupt and
// handshake levels are checked directly.
module tb_kerygma_xif_timer;
    import kerygma_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h80000010;

    logic clk_i    = 1'b0;
    logic arst_n_i = 1'b0;
    logic irq_o;

    kerygma_xif_timer_if bus ();

    kerygma_xif_timer #(
        .BASE_ADDR (BASE),
        .CNT_WIDTH (32)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .bus      (bus),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic bus_idle();
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.be    = 4'h0;
        bus.wdata = 32'h0;
    endtask

    // All bus tasks start and end 1 ns after a rising edge
    task automatic bus_write(input logic [31:0] ofs, input logic [31:0] data, input logic [3:0] be);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = BASE + ofs;
        bus.be    = be;
        bus.wdata = data;
        #1 chk("wr_ack", {31'h0, bus.ack}, 32'h1);
        @(posedge clk_i);
        #1 bus_idle();
    endtask

    task automatic bus_read(input string tag, input logic [31:0] ofs, input logic [31:0] want);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = BASE + ofs;
        bus.be   = 4'h0;
        #1 chk("rd_ack", {31'h0, bus.ack}, 32'h1);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk_i);
        #1 bus_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Response monitor / scoreboard
    always @(negedge clk_i) begin
        if (arst_n_i) begin
            if (bus.resp) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'h0, bus.resp}, 32'h0);
                end else begin
                    chk(tag_q.pop_front(), bus.rdata, exp_q.pop_front());
                end
            end else begin
                chk("rdata_idle", bus.rdata, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        arst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: reset values
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        bus_read("rst_ctrl",    OFS_CTRL,    32'h0);
        bus_read("rst_presc",   OFS_PRESC,   32'h0);
        bus_read("rst_count",   OFS_COUNT,   32'h0);
        bus_read("rst_compare", OFS_COMPARE, 32'hFFFFFFFF);
        bus_read("rst_status",  OFS_STATUS,  32'h0);

        // 2: autoreload period 4, COUNT cycles 0..3, pend after 4 clocks
        bus_write(OFS_PRESC,   32'h0, 4'hF);
        bus_write(OFS_COMPARE, 32'h3, 4'hF);
        bus_write(OFS_CTRL,    32'h7, 4'hF);
        chk("t2_irq_start", {31'h0, irq_o}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read("t2_count", OFS_COUNT, 32'(i % 4));
            chk("t2_irq", {31'h0, irq_o}, (i >= 3) ? 32'h1 : 32'h0);
        end
        bus_write(OFS_CTRL,   32'h0, 4'hF);
        bus_write(OFS_STATUS, 32'h1, 4'hF);
        bus_write(OFS_COUNT,  32'h0, 4'hF);
        chk("t2_irq_clr", {31'h0, irq_o}, 32'h0);
        bus_read("t2_status", OFS_STATUS, 32'h0);

        // 3: oneshot, PRESC=9, COMPARE=1 -> match 20 clocks after enable
        bus_write(OFS_PRESC,   32'h9, 4'hF);
        bus_write(OFS_COMPARE, 32'h1, 4'hF);
        bus_write(OFS_CTRL,    32'hB, 4'hF);
        for (int k = 1; k <= 25; k++) begin
            idle(1);
            chk("t3_irq", {31'h0, irq_o}, (k >= 20) ? 32'h1 : 32'h0);
        end
        bus_read("t3_ctrl",  OFS_CTRL,  32'hA);
        bus_read("t3_count", OFS_COUNT, 32'h2);
        idle(30);
        bus_read("t3_count_hold", OFS_COUNT, 32'h2);
        bus_write(OFS_STATUS, 32'h1, 4'hF);
        chk("t3_irq_w1c", {31'h0, irq_o}, 32'h0);
        bus_read("t3_status", OFS_STATUS, 32'h0);

        // 4: byte lanes, be=0, window edges
        bus_write(OFS_COMPARE, 32'h0, 4'hF);
        bus_write(OFS_COMPARE, 32'hAABBCCDD, 4'b0101);
        bus_read("t4_lanes", OFS_COMPARE, 32'h00BB00DD);
        bus_write(OFS_COMPARE, 32'hFFFFFFFF, 4'h0);
        bus_read("t4_be0", OFS_COMPARE, 32'h00BB00DD);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = BASE + 32'h14;
        #1 chk("t4_ack_above", {31'h0, bus.ack}, 32'h0);
        bus.addr = BASE - 32'h4;
        #1 chk("t4_ack_below", {31'h0, bus.ack}, 32'h0);
        @(posedge clk_i);
        #1 bus_idle();
        bus_read("t4_ofs11", 32'h11, 32'h0);

        // 5a: COUNT write collides with a tick (tick every clock)
        bus_write(OFS_COMPARE, 32'hFFFFFFFF, 4'hF);
        bus_write(OFS_PRESC,   32'h0, 4'hF);
        bus_write(OFS_CTRL,    32'h1, 4'hF);
        idle(2);
        bus_write(OFS_COUNT, 32'd100, 4'hF);
        bus_read("t5_count_wins", OFS_COUNT, 32'd100);
        bus_write(OFS_CTRL, 32'h0, 4'hF);

        // 5b: W1C lands on the match edge -> pend stays set
        bus_write(OFS_COUNT,   32'h0, 4'hF);
        bus_write(OFS_COMPARE, 32'h3, 4'hF);
        bus_write(OFS_CTRL,    32'h3, 4'hF);
        idle(3);
        bus_write(OFS_STATUS, 32'h1, 4'hF);
        bus_read("t5_pend_wins", OFS_STATUS, 32'h1);
        chk("t5_irq", {31'h0, irq_o}, 32'h1);
        bus_write(OFS_CTRL,   32'h0, 4'hF);
        bus_write(OFS_STATUS, 32'h1, 4'hF);
        bus_read("t5_status_clr", OFS_STATUS, 32'h0);

        // 6: reset mid-run with a read in flight
        bus_write(OFS_COUNT, 32'h0, 4'hF);
        bus_write(OFS_CTRL,  32'h7, 4'hF);
        idle(6);
        chk("t6_irq_pre", {31'h0, irq_o}, 32'h1);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = BASE + OFS_COUNT;
        @(posedge clk_i);
        #1 bus_idle();
        #1 arst_n_i = 1'b0;
        #1;
        chk("t6_resp",  {31'h0, bus.resp}, 32'h0);
        chk("t6_rdata", bus.rdata, 32'h0);
        chk("t6_irq",   {31'h0, irq_o}, 32'h0);
        @(negedge clk_i);
        #1 arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus_read("t6_ctrl",    OFS_CTRL,    32'h0);
        bus_read("t6_presc",   OFS_PRESC,   32'h0);
        bus_read("t6_count",   OFS_COUNT,   32'h0);
        bus_read("t6_compare", OFS_COMPARE, 32'hFFFFFFFF);
        bus_read("t6_status",  OFS_STATUS,  32'h0);
        chk("t6_irq_after", {31'h0, irq_o}, 32'h0);

        idle(3);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
